pwm_wave_sequencer: RTL
=======================

Name: pwm_wave_sequencer

Overview:
Plays a host-loaded table of pulse widths into one pwm instance, one table entry per sample interval. It drives the pwm's update/pulse_width/enable inputs, so arbitrary modulation envelopes run without CPU involvement. Supports one-shot and looped playback, with start/stop control and busy/done status.

Parameters:
WAVE_LEN, 1024, PWM period in pwm steps; sets pulse_width range
WAVE_LEN_WIDTH, $clog2(WAVE_LEN+1), pulse_width width
DEPTH, 256, table entries
ADDR_WIDTH, $clog2(DEPTH), table address width
PERIOD_WIDTH, 32, sample_period width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
wr_en  in  1  table write strobe
wr_addr  in  ADDR_WIDTH  table write address
wr_data  in  WAVE_LEN_WIDTH  table write data
start  in  1  begin playback (level, sampled when idle)
stop  in  1  abort playback
loop_en  in  1  repeat table at end of pass
num_samples  in  ADDR_WIDTH+1  entries per pass
sample_period  in  PERIOD_WIDTH  clk cycles between updates
busy  out  1  playback active
done  out  1  one-cycle pulse at end of a one-shot pass
pwm_update  out  1  one-cycle pulse to pwm update
pwm_pulse_width  out  WAVE_LEN_WIDTH  width to pwm
pwm_enable  out  1  pwm enable

Behaviour:
- Reset: busy=0, done=0, pwm_update=0, pwm_pulse_width=0, pwm_enable=0. State is IDLE. Table contents are not cleared.
- States: IDLE, FETCH, PLAY.
- Table: simple dual-port RAM with 1-cycle read latency. Writes are accepted in any state. A read and write to the same address in the same cycle returns old data.
- IDLE -> FETCH when start=1 and num_samples!=0 and stop=0.
  - Cycle T is start acceptance: latch N=min(num_samples,DEPTH) and P=max(sample_period,2), then read addr 0.
  - start with num_samples=0 is ignored.
- FETCH: the cycle after T, rdata is captured into next_width. Go to PLAY.
- PLAY, first update at cycle T+2:
  - pwm_pulse_width<=next_width and pwm_update=1 for exactly one cycle.
  - In the same cycle, read the next index (idx+1, or 0 if idx=N-1) and load the interval counter.
- Subsequent updates occur every P cycles exactly. pwm_pulse_width changes only on update cycles and is stable in between.
- End of pass: at the interval boundary after index N-1's update:
  - loop_en=1 (sampled at this boundary, not at start): update with index 0 and continue.
  - loop_en=0: done=1 for one cycle, busy=0 that same cycle, and return to IDLE. No update is issued.
- busy=1 and pwm_enable=1 in FETCH and PLAY. pwm_pulse_width holds its last value after stop or done.
- stop=1 in FETCH or PLAY: IDLE next cycle, busy=0, no done pulse, and no update that cycle. stop has priority over start and over a coincident update.
- start while busy is ignored. num_samples and sample_period changes during playback have no effect until the next start.
- Reset mid-playback gives reset values next cycle.
- Width rules:
  - The interval counter is PERIOD_WIDTH bits and counts down to 1.
  - The index wraps at N-1.
  - num_samples>DEPTH is clamped to DEPTH.

Decomposition:
- Package pwm_seq_pkg: state enum (IDLE/FETCH/PLAY) and the minimum-period constant (2).
- Sub-module pwm_wave_ram: DEPTH x WAVE_LEN_WIDTH simple dual-port, sync write, registered read.
- Sequencer FSM, counters and output registers live in the top.

Test Plan:
- Load table[0..3]=10,200,500,1024; N=4, P=5, loop_en=0; start at cycle T -> pwm_update at T+2,T+7,T+12,T+17 with widths 10,200,500,1024; done at T+22; busy falls at T+22.
- Same table, loop_en=1, then clear loop_en after the second pass begins -> widths 10,200,500,1024,10,200,500,1024, then done 5 cycles after the last update.
- sample_period=0 and sample_period=1 -> updates spaced 2 cycles; num_samples=0 start -> busy stays 0, no update; num_samples=DEPTH+5 -> exactly DEPTH updates per pass.
- stop asserted in the same cycle a pwm_update would occur -> no update, busy=0 next cycle, no done, pwm_pulse_width retains its previous value.
- reset asserted mid-PLAY -> all outputs 0 next cycle; a fresh start then replays from index 0 (table retained).
- Overwrite table[2] during playback before its read -> new value is played; a write to the same address in the read cycle -> old value is played.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the pwm wave sequencer.
package pwm_seq_pkg;

  // Playback sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } seq_state_t;

  // Shortest interval between pwm updates; the table prefetch needs two cycles
  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_wave_ram.sv
// Simple dual-port table RAM: synchronous write, registered read.
// A read and a write to the same address in one cycle return the old data.
module pwm_wave_ram #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port; output holds between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/pwm_wave_sequencer.sv
// Plays a host-loaded table of pulse widths into a pwm, one entry per
// sample interval, with one-shot or looped playback.
module pwm_wave_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int WAVE_LEN       = 1024,
  parameter int WAVE_LEN_WIDTH = $clog2(WAVE_LEN + 1),
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int PERIOD_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [WAVE_LEN_WIDTH-1:0] wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [ADDR_WIDTH:0]       num_samples,
  input  logic [PERIOD_WIDTH-1:0]   sample_period,
  output logic                      busy,
  output logic                      done,
  output logic                      pwm_update,
  output logic [WAVE_LEN_WIDTH-1:0] pwm_pulse_width,
  output logic                      pwm_enable
);

  localparam logic [ADDR_WIDTH:0]     DEPTH_N  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]     ONE_N    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0]   ONE_A    = ADDR_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P    = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P    = PERIOD_WIDTH'(MIN_PERIOD);

  seq_state_t                state_reg;
  logic [ADDR_WIDTH:0]       n_reg;          // entries per pass, clamped
  logic [PERIOD_WIDTH-1:0]   period_reg;     // update interval, floored
  logic [PERIOD_WIDTH-1:0]   cnt_reg;        // interval countdown, fires at 1
  logic [ADDR_WIDTH-1:0]     idx_reg;        // index currently on the pwm
  logic [WAVE_LEN_WIDTH-1:0] next_width_reg; // prefetched table entry
  logic                      rd_valid_reg;   // RAM output is fresh this cycle
  logic                      busy_reg;
  logic                      done_reg;
  logic                      pwm_update_reg;
  logic                      pwm_enable_reg;
  logic [WAVE_LEN_WIDTH-1:0] pwm_width_reg;

  logic                      accept;
  logic                      last_idx;
  logic [ADDR_WIDTH-1:0]     idx_next;
  logic                      fire;
  logic [WAVE_LEN_WIDTH-1:0] fire_width;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [WAVE_LEN_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]       n_clamped;
  logic [PERIOD_WIDTH-1:0]   period_floored;

  // Start qualification, index stepping and prefetch address
  always_comb begin
    accept         = (state_reg == IDLE) && start && !stop && (num_samples != '0);
    n_clamped      = (num_samples > DEPTH_N) ? DEPTH_N : num_samples;
    period_floored = (sample_period < MIN_P) ? MIN_P : sample_period;
    last_idx       = ({1'b0, idx_reg} == (n_reg - ONE_N));
    idx_next       = last_idx ? '0 : (idx_reg + ONE_A);
    fire           = (state_reg == PLAY) && (cnt_reg == ONE_P);
    // With a 2-cycle period the prefetch lands in the firing cycle itself
    fire_width     = rd_valid_reg ? rd_data : next_width_reg;
    // Read entry 0 on acceptance; prefetch the following entry on each update
    rd_en          = accept || ((state_reg == PLAY) && pwm_update_reg);
    rd_addr        = accept ? '0 : idx_next;
  end

  pwm_wave_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WAVE_LEN_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Sequencer FSM with registered status and pwm outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      period_reg     <= MIN_P;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      next_width_reg <= '0;
      rd_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pwm_update_reg <= 1'b0;
      pwm_enable_reg <= 1'b0;
      pwm_width_reg  <= '0;
    end else begin
      pwm_update_reg <= 1'b0;
      done_reg       <= 1'b0;
      rd_valid_reg   <= rd_en;
      if (rd_valid_reg) begin
        next_width_reg <= rd_data;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            n_reg          <= n_clamped;
            period_reg     <= period_floored;
            state_reg      <= FETCH;
            busy_reg       <= 1'b1;
            pwm_enable_reg <= 1'b1;
          end
        end

        FETCH: begin
          if (stop) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            pwm_enable_reg <= 1'b0;
          end else begin
            // Entry 0 is on the RAM output now; present it immediately
            state_reg      <= PLAY;
            pwm_update_reg <= 1'b1;
            pwm_width_reg  <= fire_width;
            idx_reg        <= '0;
            cnt_reg        <= period_reg;
          end
        end

        PLAY: begin
          if (stop) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            pwm_enable_reg <= 1'b0;
          end else if (fire) begin
            if (last_idx && !loop_en) begin
              state_reg      <= IDLE;
              done_reg       <= 1'b1;
              busy_reg       <= 1'b0;
              pwm_enable_reg <= 1'b0;
            end else begin
              pwm_update_reg <= 1'b1;
              pwm_width_reg  <= fire_width;
              idx_reg        <= idx_next;
              cnt_reg        <= period_reg;
            end
          end else begin
            cnt_reg <= cnt_reg - ONE_P;
          end
        end

        default: begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          pwm_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign pwm_update      = pwm_update_reg;
  assign pwm_pulse_width = pwm_width_reg;
  assign pwm_enable      = pwm_enable_reg;

endmodule
